// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/ack data-memory port, stalls upstream while an access
// is outstanding, aborts stuck accesses after TIMEOUT wait cycles, and registers MEM/WB values.
module mem_access_stage #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ex_pc_plus1,
  input  logic [DATA_W-1:0] ex_rd2,
  input  logic [1:0]        ex_rd_idx,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [1:0]        ex_memtoreg,
  input  logic              ex_regwrite,
  input  logic [DATA_W-1:0] ex_ip,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_o,
  output logic              mem_err,
  output logic [DATA_W-1:0] wb_pc_plus1,
  output logic [DATA_W-1:0] wb_alu_res,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [DATA_W-1:0] wb_ip,
  output logic [1:0]        wb_rd_idx,
  output logic [1:0]        wb_memtoreg,
  output logic              wb_regwrite
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_wait_cnt;
  logic [DATA_W-1:0] r_pc, r_ip;
  logic [1:0]        r_rd_idx, r_memtoreg;
  logic              r_regwrite;
  logic              w_mem_op, w_timeout, w_done;

  assign w_mem_op  = ex_memread | ex_memwrite;
  assign w_timeout = (r_wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Ack and timeout both release the pipeline on the same edge the stage returns to IDLE.
  always_comb begin
    w_next  = r_state;
    stall_o = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: if (w_mem_op) begin
        stall_o = 1'b1;
        w_next  = WAIT;
      end
      WAIT: if (mem_ack || w_timeout) begin
        w_done = 1'b1;
        w_next = IDLE;
      end else begin
        stall_o = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // mem_addr doubles as the latched ALU result for the eventual writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      r_pc        <= '0;
      r_ip        <= '0;
      r_rd_idx    <= '0;
      r_memtoreg  <= '0;
      r_regwrite  <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_err     <= 1'b0;
      wb_pc_plus1 <= '0;
      wb_alu_res  <= '0;
      wb_mem_data <= '0;
      wb_ip       <= '0;
      wb_rd_idx   <= '0;
      wb_memtoreg <= '0;
      wb_regwrite <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_mem_op) begin
        mem_req     <= 1'b1;
        mem_we      <= ex_memwrite;
        mem_addr    <= ex_alu_res;
        mem_wdata   <= ex_rd2;
        r_pc        <= ex_pc_plus1;
        r_ip        <= ex_ip;
        r_rd_idx    <= ex_rd_idx;
        r_memtoreg  <= ex_memtoreg;
        r_regwrite  <= ex_regwrite;
        r_wait_cnt  <= '0;
        wb_regwrite <= 1'b0;
      end else begin
        wb_pc_plus1 <= ex_pc_plus1;
        wb_alu_res  <= ex_alu_res;
        wb_mem_data <= '0;
        wb_ip       <= ex_ip;
        wb_rd_idx   <= ex_rd_idx;
        wb_memtoreg <= ex_memtoreg;
        wb_regwrite <= ex_regwrite;
      end
    end else if (w_done) begin
      mem_req     <= 1'b0;
      wb_pc_plus1 <= r_pc;
      wb_alu_res  <= mem_addr;
      wb_ip       <= r_ip;
      wb_rd_idx   <= r_rd_idx;
      wb_memtoreg <= r_memtoreg;
      if (mem_ack) begin
        wb_regwrite <= r_regwrite;
        wb_mem_data <= mem_we ? '0 : mem_rdata;
      end else begin
        wb_regwrite <= 1'b0;
        wb_mem_data <= '0;
        mem_err     <= 1'b1;
      end
    end else begin
      r_wait_cnt  <= r_wait_cnt + 1'b1;
      wb_regwrite <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized + directed bench for mem_access_stage against a transaction-level model.
module tb_mem_access_stage;
  localparam int DW = 8;
  localparam int TO = 6;

  logic clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] ex_pc_plus1 = '0, ex_rd2 = '0, ex_alu_res = '0, ex_ip = '0, mem_rdata = '0;
  logic [1:0] ex_rd_idx = '0, ex_memtoreg = '0;
  logic ex_memread = 1'b0, ex_memwrite = 1'b0, ex_regwrite = 1'b0, mem_ack = 1'b0;
  logic mem_req, mem_we, stall_o, mem_err, wb_regwrite;
  logic [DW-1:0] mem_addr, mem_wdata, wb_pc_plus1, wb_alu_res, wb_mem_data, wb_ip;
  logic [1:0] wb_rd_idx, wb_memtoreg;

  mem_access_stage #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ex_pc_plus1(ex_pc_plus1), .ex_rd2(ex_rd2), .ex_rd_idx(ex_rd_idx),
    .ex_alu_res(ex_alu_res), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_ip(ex_ip),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_o(stall_o), .mem_err(mem_err),
    .wb_pc_plus1(wb_pc_plus1), .wb_alu_res(wb_alu_res), .wb_mem_data(wb_mem_data),
    .wb_ip(wb_ip), .wb_rd_idx(wb_rd_idx), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access, counted in elapsed wait cycles.
  bit m_busy = 0;
  int m_waited = 0;
  logic [DW-1:0] m_pc = '0, m_ip = '0;
  logic [1:0] m_idx = '0, m_mtr = '0;
  bit m_rw = 0;
  logic e_req = 0, e_we = 0, e_err = 0, e_rw = 0;
  logic [DW-1:0] e_addr = '0, e_wdata = '0, e_pc = '0, e_alu = '0, e_md = '0, e_ip = '0;
  logic [1:0] e_idx = '0, e_mtr = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_waited = 0; e_req = 0; e_we = 0; e_err = 0; e_rw = 0;
      e_addr = 0; e_wdata = 0; e_pc = 0; e_alu = 0; e_md = 0; e_ip = 0; e_idx = 0; e_mtr = 0;
    end else if (!m_busy) begin
      if (ex_memread || ex_memwrite) begin
        m_busy = 1; m_waited = 0;
        m_pc = ex_pc_plus1; m_ip = ex_ip; m_idx = ex_rd_idx; m_mtr = ex_memtoreg; m_rw = ex_regwrite;
        e_req = 1; e_we = ex_memwrite; e_addr = ex_alu_res; e_wdata = ex_rd2; e_rw = 0;
      end else begin
        e_pc = ex_pc_plus1; e_alu = ex_alu_res; e_ip = ex_ip; e_idx = ex_rd_idx;
        e_mtr = ex_memtoreg; e_rw = ex_regwrite; e_md = 0;
      end
    end else begin
      m_waited++;
      if (mem_ack || m_waited == TO) begin
        m_busy = 0; e_req = 0;
        e_pc = m_pc; e_alu = e_addr; e_ip = m_ip; e_idx = m_idx; e_mtr = m_mtr;
        if (mem_ack) begin
          e_rw = m_rw; e_md = e_we ? '0 : mem_rdata;
        end else begin
          e_rw = 0; e_md = 0; e_err = 1;
        end
      end else begin
        e_rw = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", mem_req, e_req);
      check("mem_err", mem_err, e_err);
      if (e_req) begin
        check("mem_we", mem_we, e_we);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
      end
      check("wb_pc_plus1", wb_pc_plus1, e_pc);
      check("wb_alu_res", wb_alu_res, e_alu);
      check("wb_mem_data", wb_mem_data, e_md);
      check("wb_ip", wb_ip, e_ip);
      check("wb_rd_idx", wb_rd_idx, e_idx);
      check("wb_memtoreg", wb_memtoreg, e_mtr);
      check("wb_regwrite", wb_regwrite, e_rw);
      if (!rst)
        check("stall_o", stall_o,
              m_busy ? !(mem_ack || (m_waited + 1 >= TO)) : (ex_memread | ex_memwrite));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    ex_memread = 0; ex_memwrite = 0; ex_regwrite = 0; ex_alu_res = 0; ex_rd2 = 0;
    ex_rd_idx = 0; ex_pc_plus1 = 0; ex_ip = 0; ex_memtoreg = 0;
  endtask

  task automatic drive_ex(input bit rd, input bit wr, input logic [DW-1:0] alu,
                          input logic [DW-1:0] rd2, input bit rw, input logic [1:0] idx);
    ex_memread = rd; ex_memwrite = wr; ex_alu_res = alu; ex_rd2 = rd2; ex_regwrite = rw;
    ex_rd_idx = idx; ex_pc_plus1 = DW'($urandom); ex_ip = DW'($urandom);
    ex_memtoreg = 2'($urandom);
  endtask

  task automatic drive_rand();
    drive_ex(1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom), 1'($urandom), 2'($urandom));
  endtask

  initial begin
    int s, r;
    rst = 1; drive_idle();
    tick(); tick();
    rst = 0;
    chk_en = 1;
    check("rst_req", mem_req, 0);
    check("rst_err", mem_err, 0);
    check("rst_wb_rw", wb_regwrite, 0);
    check("rst_stall", stall_o, 0);

    // ALU op passes straight through
    drive_ex(0, 0, 8'h3C, 8'h00, 1, 2); #1;
    check("alu_stall", stall_o, 0);
    tick();
    check("alu_wb_alu", wb_alu_res, 8'h3C);
    check("alu_wb_rw", wb_regwrite, 1);
    check("alu_wb_idx", wb_rd_idx, 2);

    // Load, ack in third wait cycle; upstream garbage during wait must be ignored
    drive_ex(1, 0, 8'h10, 8'h00, 1, 1); #1;
    s = int'(stall_o); r = 0;
    tick();
    check("ld_addr", mem_addr, 8'h10);
    check("ld_we", mem_we, 0);
    for (int i = 0; i < 2; i++) begin
      drive_rand(); #1;
      s += int'(stall_o); r += int'(mem_req);
      tick();
    end
    drive_idle(); mem_ack = 1; mem_rdata = 8'hA5; #1;
    s += int'(stall_o); r += int'(mem_req);
    tick(); mem_ack = 0;
    check("ld_wb_data", wb_mem_data, 8'hA5);
    check("ld_wb_rw", wb_regwrite, 1);
    check("ld_stall_cycles", s, 3);
    check("ld_req_cycles", r, 3);
    tick();
    check("ld_rw_once", wb_regwrite, 0);

    // Store, ack in first wait cycle
    drive_ex(0, 1, 8'h20, 8'h5A, 0, 3);
    tick();
    drive_idle(); mem_ack = 1; mem_rdata = 8'hEE; #1;
    check("st_we", mem_we, 1);
    check("st_wdata", mem_wdata, 8'h5A);
    check("st_addr", mem_addr, 8'h20);
    tick(); mem_ack = 0;
    check("st_wb_data", wb_mem_data, 0);

    // Read+write together, ack on the timeout cycle: normal completion
    drive_ex(1, 1, 8'h44, 8'h77, 1, 0);
    tick(); drive_idle();
    check("rw_we", mem_we, 1);
    repeat (TO - 1) tick();
    mem_ack = 1; mem_rdata = 8'hFF;
    tick(); mem_ack = 0;
    check("rw_err", mem_err, 0);
    check("rw_wb_data", wb_mem_data, 0);
    check("rw_wb_rw", wb_regwrite, 1);

    // Load with no ack: timeout abort, sticky error
    drive_ex(1, 0, 8'h55, 8'h00, 1, 1);
    tick(); drive_idle();
    repeat (TO - 1) tick();
    #1 check("to_stall", stall_o, 0);
    tick();
    check("to_err", mem_err, 1);
    check("to_wb_rw", wb_regwrite, 0);
    check("to_req", mem_req, 0);
    tick(); tick();
    check("to_err_sticky", mem_err, 1);

    // Reset during wait, then a stray ack
    drive_ex(1, 0, 8'h66, 8'h00, 1, 1);
    tick(); drive_idle();
    tick();
    rst = 1; tick(); rst = 0;
    mem_ack = 1; mem_rdata = 8'h99;
    tick(); mem_ack = 0;
    check("rs_req", mem_req, 0);
    check("rs_err", mem_err, 0);
    check("rs_wb_rw", wb_regwrite, 0);
    check("rs_wb_data", wb_mem_data, 0);
    check("rs_wb_alu", wb_alu_res, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      mem_rdata = DW'($urandom);
      if (!m_busy) begin
        drive_ex(1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom), 1'($urandom), 2'($urandom));
        if ($urandom_range(0, 2) != 0) begin ex_memread = 0; ex_memwrite = 0; end
        mem_ack = ($urandom_range(0, 9) == 0);
      end else begin
        drive_rand();
        mem_ack = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    rst = 0; mem_ack = 0; drive_idle();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
